// File: rtl/ir_nec_rx_decoder.sv
// NEC IR receiver: conditions the demodulated input, measures mark/space widths in
// prescaled ticks and decodes frames / repeat codes into single-cycle strobes.
module ir_nec_rx_decoder #(
  parameter int unsigned CLK_DIV       = 120,
  parameter bit          IR_ACTIVE_LOW = 1'b1,
  parameter bit          EXT_ADDR      = 1'b0,
  parameter int unsigned LEAD_MARK_MIN = 800,
  parameter int unsigned LEAD_MARK_MAX = 1000,
  parameter int unsigned LEAD_SPC_MIN  = 400,
  parameter int unsigned LEAD_SPC_MAX  = 500,
  parameter int unsigned RPT_SPC_MIN   = 200,
  parameter int unsigned RPT_SPC_MAX   = 250,
  parameter int unsigned BIT_MIN       = 40,
  parameter int unsigned BIT_MAX       = 70,
  parameter int unsigned ONE_MIN       = 140,
  parameter int unsigned ONE_MAX       = 200,
  parameter int unsigned TIMEOUT       = 1100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_in,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        data_valid,
  output logic        repeat_valid,
  output logic        err,
  output logic        busy
);

  localparam int unsigned W_W  = 11;
  localparam int unsigned PW   = $clog2(CLK_DIV);
  localparam int unsigned BC_W = 5;
  localparam logic [W_W-1:0] W_SAT = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_RPT_STOP
  } state_t;

  state_t            state, state_nxt;
  logic              sync1, sync2, mark_d, rise, fall, mark_n;
  logic [PW-1:0]     pre;
  logic [W_W-1:0]    width, w_meas;
  logic              tick, timed_out;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [31:0]       shreg, sh_nxt;
  logic              have_frame, have_nxt;
  logic [15:0]       addr_nxt;
  logic [7:0]        cmd_nxt;
  logic              dv_nxt, rv_nxt, abort, frame_ok;

  function automatic logic in_win(input logic [W_W-1:0] w, input int unsigned lo,
                                  input int unsigned hi);
    return (w >= W_W'(lo)) && (w <= W_W'(hi));
  endfunction

  assign mark_n = sync2 ^ IR_ACTIVE_LOW;

  // Synchronizer, third stage and registered edge flags; resets to the idle (space) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= IR_ACTIVE_LOW;
      sync2  <= IR_ACTIVE_LOW;
      mark_d <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1  <= ir_in;
      sync2  <= sync1;
      mark_d <= mark_n;
      rise   <= mark_n & ~mark_d;
      fall   <= ~mark_n & mark_d;
    end
  end

  // Width including the tick that lands on the closing edge, so an N-tick interval reads N
  assign tick      = (pre == PW'(CLK_DIV - 1));
  assign w_meas    = (tick && (width != W_SAT)) ? width + W_W'(1) : width;
  assign timed_out = (state != S_IDLE) && (width >= W_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      width <= '0;
    end else if (rise || fall) begin
      pre   <= '0;
      width <= '0;
    end else begin
      pre   <= tick ? '0 : pre + PW'(1);
      width <= w_meas;
    end
  end

  assign frame_ok = (shreg[31:24] == ~shreg[23:16]) &&
                    ((EXT_ADDR == 1'b1) || (shreg[15:8] == ~shreg[7:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    sh_nxt      = shreg;
    have_nxt    = have_frame;
    addr_nxt    = addr;
    cmd_nxt     = cmd;
    dv_nxt      = 1'b0;
    rv_nxt      = 1'b0;
    abort       = 1'b0;
    if (timed_out) begin
      abort = 1'b1;
    end else begin
      case (state)
        S_IDLE: if (rise) state_nxt = S_LEAD_MARK;
        S_LEAD_MARK: if (fall) begin
          if (in_win(w_meas, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_nxt = S_LEAD_SPACE;
          else abort = 1'b1;
        end
        S_LEAD_SPACE: if (rise) begin
          if (in_win(w_meas, LEAD_SPC_MIN, LEAD_SPC_MAX)) begin
            bit_cnt_nxt = '0;
            state_nxt   = S_BIT_MARK;
          end else if (in_win(w_meas, RPT_SPC_MIN, RPT_SPC_MAX)) begin
            state_nxt = S_RPT_STOP;
          end else begin
            abort = 1'b1;
          end
        end
        S_BIT_MARK: if (fall) begin
          if (in_win(w_meas, BIT_MIN, BIT_MAX)) state_nxt = S_BIT_SPACE;
          else abort = 1'b1;
        end
        S_BIT_SPACE: if (rise) begin
          if (in_win(w_meas, BIT_MIN, BIT_MAX) || in_win(w_meas, ONE_MIN, ONE_MAX)) begin
            sh_nxt      = {in_win(w_meas, ONE_MIN, ONE_MAX), shreg[31:1]};
            bit_cnt_nxt = bit_cnt + BC_W'(1);
            state_nxt   = (bit_cnt == BC_W'(31)) ? S_STOP_MARK : S_BIT_MARK;
          end else begin
            abort = 1'b1;
          end
        end
        S_STOP_MARK: if (fall) begin
          if (in_win(w_meas, BIT_MIN, BIT_MAX) && frame_ok) begin
            addr_nxt  = shreg[15:0];
            cmd_nxt   = shreg[23:16];
            dv_nxt    = 1'b1;
            have_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            abort = 1'b1;
          end
        end
        S_RPT_STOP: if (fall) begin
          if (in_win(w_meas, BIT_MIN, BIT_MAX) && have_frame) begin
            rv_nxt    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            abort = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    if (abort) begin
      state_nxt   = S_IDLE;
      sh_nxt      = '0;
      bit_cnt_nxt = '0;
      have_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      shreg        <= '0;
      have_frame   <= 1'b0;
      addr         <= '0;
      cmd          <= '0;
      data_valid   <= 1'b0;
      repeat_valid <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      bit_cnt      <= bit_cnt_nxt;
      shreg        <= sh_nxt;
      have_frame   <= have_nxt;
      addr         <= addr_nxt;
      cmd          <= cmd_nxt;
      data_valid   <= dv_nxt;
      repeat_valid <= rv_nxt;
      err          <= abort;
      busy         <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ir_nec_rx_decoder.sv
// Bench for ir_nec_rx_decoder: drives NEC waveforms into a standard-address and an
// extended-address instance and checks strobes/outputs against a byte-level model.
`timescale 1ns/1ps
module tb_ir_nec_rx_decoder;

  localparam int unsigned DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ir;
  logic [15:0] addr_a, addr_b;
  logic [7:0]  cmd_a, cmd_b;
  logic        dv_a, rv_a, err_a, busy_a;
  logic        dv_b, rv_b, err_b, busy_b;

  int checks = 0;
  int errors = 0;
  int dv_cnt[2], rv_cnt[2], er_cnt[2];
  int excl_bad = 0;
  bit prev_a = 0, prev_b = 0;

  logic [15:0] m_addr, mb_addr;
  logic [7:0]  m_cmd, mb_cmd;
  bit          m_have;

  always #5 clk = ~clk;

  ir_nec_rx_decoder #(.CLK_DIV(DIV), .EXT_ADDR(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .ir_in(ir[0]), .addr(addr_a), .cmd(cmd_a),
    .data_valid(dv_a), .repeat_valid(rv_a), .err(err_a), .busy(busy_a));

  ir_nec_rx_decoder #(.CLK_DIV(DIV), .EXT_ADDR(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ir_in(ir[1]), .addr(addr_b), .cmd(cmd_b),
    .data_valid(dv_b), .repeat_valid(rv_b), .err(err_b), .busy(busy_b));

  // Strobe counters plus exclusivity / back-to-back watch
  always @(negedge clk) begin
    int na, nb;
    na = int'(dv_a === 1'b1) + int'(rv_a === 1'b1) + int'(err_a === 1'b1);
    nb = int'(dv_b === 1'b1) + int'(rv_b === 1'b1) + int'(err_b === 1'b1);
    if (dv_a === 1'b1) dv_cnt[0]++;
    if (rv_a === 1'b1) rv_cnt[0]++;
    if (err_a === 1'b1) er_cnt[0]++;
    if (dv_b === 1'b1) dv_cnt[1]++;
    if (rv_b === 1'b1) rv_cnt[1]++;
    if (err_b === 1'b1) er_cnt[1]++;
    if (na > 1 || nb > 1 || (prev_a && na > 0) || (prev_b && nb > 0)) excl_bad++;
    prev_a = (na > 0);
    prev_b = (nb > 0);
  end

  initial begin
    #(1_500_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int jit(input int amp);
    return int'($urandom_range(2 * amp)) - amp;
  endfunction

  function automatic logic [31:0] make_frame(input logic [15:0] a, input logic [7:0] c);
    logic [7:0] ci;
    ci = 8'(255 - int'(c));
    return {ci, c, a};
  endfunction

  function automatic logic [15:0] std_addr(input logic [7:0] a);
    return {8'(255 - int'(a)), a};
  endfunction

  // Inverse pairs are bytes summing to 0xFF
  function automatic bit frame_ok(input logic [31:0] b, input bit ext);
    bit ok;
    ok = (int'(b[31:24]) + int'(b[23:16]) == 255);
    if (!ext && (int'(b[15:8]) + int'(b[7:0]) != 255)) ok = 0;
    return ok;
  endfunction

  // Raw receiver is active-low: mark drives ir low
  task automatic hold(input int d, input logic is_mark, input int ticks);
    ir[d] = ~is_mark;
    repeat (ticks * DIV) @(negedge clk);
  endtask

  task automatic send_leader(input int d, input int spc, input int amp);
    hold(d, 1'b1, 900 + jit(amp * 4));
    hold(d, 1'b0, spc + jit(amp * 2));
  endtask

  task automatic send_bits(input int d, input logic [31:0] b, input int n, input int amp);
    for (int i = 0; i < n; i++) begin
      hold(d, 1'b1, 56 + jit(amp));
      hold(d, 1'b0, (b[i] ? 169 : 56) + jit(amp));
    end
  endtask

  task automatic send_frame(input int d, input logic [31:0] b, input int amp);
    send_leader(d, 450, amp);
    send_bits(d, b, 32, amp);
    hold(d, 1'b1, 56 + jit(amp));
    hold(d, 1'b0, 30);
  endtask

  task automatic send_repeat(input int d);
    hold(d, 1'b1, 900);
    hold(d, 1'b0, 225);
    hold(d, 1'b1, 56);
    hold(d, 1'b0, 30);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ir = 2'b11;
    repeat (5) @(negedge clk);
    checks++; if (addr_a !== 16'h0) begin errors++; $display("FAIL reset_addr got %h exp 0000", addr_a); end
    checks++; if (cmd_a !== 8'h0) begin errors++; $display("FAIL reset_cmd got %h exp 00", cmd_a); end
    checks++; if ({dv_a, rv_a, err_a, busy_a} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {dv_a, rv_a, err_a, busy_a}); end
    checks++; if ({addr_b, cmd_b, busy_b} !== 25'h0) begin errors++; $display("FAIL reset_b got %h exp 0", {addr_b, cmd_b, busy_b}); end
    rst_n = 1'b1;
    m_addr = '0; m_cmd = '0; m_have = 0; mb_addr = '0; mb_cmd = '0;
    repeat (20) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy_a); end
  endtask

  task automatic test_repeat_no_frame();
    int e0, r0;
    e0 = er_cnt[0]; r0 = rv_cnt[0];
    send_repeat(0);
    m_have = 0;
    checks++; if (er_cnt[0] - e0 !== 1) begin errors++; $display("FAIL rpt_no_frame_err got %0d exp 1", er_cnt[0] - e0); end
    checks++; if (rv_cnt[0] - r0 !== 0) begin errors++; $display("FAIL rpt_no_frame_rv got %0d exp 0", rv_cnt[0] - r0); end
  endtask

  task automatic test_frame();
    logic [31:0] b;
    int d0, e0;
    b = {8'hBA, 8'h45, 8'hFB, 8'h04};
    d0 = dv_cnt[0]; e0 = er_cnt[0];
    send_leader(0, 450, 0);
    send_bits(0, b, 32, 0);
    hold(0, 1'b1, 56);
    ir[0] = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL latency_early got %b exp 0", dv_a); end
    @(negedge clk);
    checks++; if (dv_a !== 1'b1) begin errors++; $display("FAIL latency_4clk got %b exp 1", dv_a); end
    @(negedge clk);
    checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL dv_one_cycle got %b exp 0", dv_a); end
    hold(0, 1'b0, 30);
    if (frame_ok(b, 0)) begin m_addr = b[15:0]; m_cmd = b[23:16]; m_have = 1; end
    checks++; if (dv_cnt[0] - d0 !== 1) begin errors++; $display("FAIL frame_dv got %0d exp 1", dv_cnt[0] - d0); end
    checks++; if (er_cnt[0] - e0 !== 0) begin errors++; $display("FAIL frame_err got %0d exp 0", er_cnt[0] - e0); end
    checks++; if (addr_a !== 16'hFB04 || addr_a !== m_addr) begin errors++; $display("FAIL frame_addr got %h exp FB04", addr_a); end
    checks++; if (cmd_a !== 8'h45) begin errors++; $display("FAIL frame_cmd got %h exp 45", cmd_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL frame_busy got %b exp 0", busy_a); end
  endtask

  task automatic test_ext();
    logic [31:0] b;
    int d0;
    b = {8'hBA, 8'h45, 8'h34, 8'h12};
    d0 = dv_cnt[1];
    send_frame(1, b, 0);
    mb_addr = b[15:0]; mb_cmd = b[23:16];
    checks++; if (dv_cnt[1] - d0 !== 1) begin errors++; $display("FAIL ext_dv got %0d exp 1", dv_cnt[1] - d0); end
    checks++; if (addr_b !== 16'h3412) begin errors++; $display("FAIL ext_addr got %h exp 3412", addr_b); end
    checks++; if (cmd_b !== 8'h45) begin errors++; $display("FAIL ext_cmd got %h exp 45", cmd_b); end
  endtask

  task automatic test_ext_random();
    logic [31:0] b;
    logic [7:0]  c, ci;
    bit          ok;
    int          d0, e0;
    c  = 8'($urandom);
    ci = ($urandom_range(1) == 1) ? 8'(255 - int'(c)) : 8'($urandom);
    b  = {ci, c, 16'($urandom)};
    ok = frame_ok(b, 1);
    d0 = dv_cnt[1]; e0 = er_cnt[1];
    send_frame(1, b, 4);
    if (ok) begin mb_addr = b[15:0]; mb_cmd = c; end
    checks++; if (dv_cnt[1] - d0 !== int'(ok)) begin errors++; $display("FAIL ext_rand_dv got %0d exp %0d", dv_cnt[1] - d0, int'(ok)); end
    checks++; if (er_cnt[1] - e0 !== int'(!ok)) begin errors++; $display("FAIL ext_rand_err got %0d exp %0d", er_cnt[1] - e0, int'(!ok)); end
    checks++; if (addr_b !== mb_addr || cmd_b !== mb_cmd) begin errors++; $display("FAIL ext_rand_out got %h/%h exp %h/%h", addr_b, cmd_b, mb_addr, mb_cmd); end
  endtask

  task automatic test_repeat();
    int d0, r0, e0;
    d0 = dv_cnt[0]; r0 = rv_cnt[0]; e0 = er_cnt[0];
    send_repeat(0);
    checks++; if (rv_cnt[0] - r0 !== int'(m_have)) begin errors++; $display("FAIL repeat_rv got %0d exp %0d", rv_cnt[0] - r0, int'(m_have)); end
    checks++; if (dv_cnt[0] - d0 !== 0 || er_cnt[0] - e0 !== 0) begin errors++; $display("FAIL repeat_other got dv %0d err %0d exp 0 0", dv_cnt[0] - d0, er_cnt[0] - e0); end
    checks++; if (addr_a !== m_addr || cmd_a !== m_cmd) begin errors++; $display("FAIL repeat_hold got %h/%h exp %h/%h", addr_a, cmd_a, m_addr, m_cmd); end
  endtask

  task automatic test_bad_inverse();
    logic [31:0] b;
    int d0, e0;
    b = {8'hBB, 8'h45, 8'hFB, 8'h04};
    d0 = dv_cnt[0]; e0 = er_cnt[0];
    send_frame(0, b, 0);
    if (!frame_ok(b, 0)) m_have = 0;
    checks++; if (er_cnt[0] - e0 !== 1) begin errors++; $display("FAIL bad_inv_err got %0d exp 1", er_cnt[0] - e0); end
    checks++; if (dv_cnt[0] - d0 !== 0) begin errors++; $display("FAIL bad_inv_dv got %0d exp 0", dv_cnt[0] - d0); end
    checks++; if (addr_a !== 16'hFB04 || cmd_a !== 8'h45) begin errors++; $display("FAIL bad_inv_hold got %h/%h exp FB04/45", addr_a, cmd_a); end
  endtask

  task automatic test_timeout();
    logic [31:0] b;
    int d0, e0;
    b = make_frame(std_addr(8'($urandom)), 8'h16);
    e0 = er_cnt[0];
    send_leader(0, 450, 2);
    send_bits(0, b, 10, 4);
    hold(0, 1'b1, 56);
    hold(0, 1'b0, 1090);
    checks++; if (er_cnt[0] - e0 !== 0 || busy_a !== 1'b1) begin errors++; $display("FAIL timeout_early got err %0d busy %b exp 0 1", er_cnt[0] - e0, busy_a); end
    hold(0, 1'b0, 60);
    checks++; if (er_cnt[0] - e0 !== 1 || busy_a !== 1'b0) begin errors++; $display("FAIL timeout_err got err %0d busy %b exp 1 0", er_cnt[0] - e0, busy_a); end
    hold(0, 1'b0, 50);
    m_have = 0;
    d0 = dv_cnt[0]; e0 = er_cnt[0];
    send_frame(0, b, 4);
    if (frame_ok(b, 0)) begin m_addr = b[15:0]; m_cmd = b[23:16]; m_have = 1; end
    checks++; if (dv_cnt[0] - d0 !== 1 || er_cnt[0] - e0 !== 0) begin errors++; $display("FAIL after_timeout_dv got dv %0d err %0d exp 1 0", dv_cnt[0] - d0, er_cnt[0] - e0); end
    checks++; if (addr_a !== m_addr || cmd_a !== 8'h16) begin errors++; $display("FAIL after_timeout_out got %h/%h exp %h/16", addr_a, cmd_a, m_addr); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] b;
    int d0, e0;
    b = make_frame(std_addr(8'($urandom)), 8'($urandom));
    send_leader(0, 450, 2);
    send_bits(0, b, 15, 4);
    hold(0, 1'b1, 56);
    hold(0, 1'b0, 20);
    e0 = er_cnt[0];
    rst_n = 1'b0;
    #1;
    checks++; if (addr_a !== 16'h0 || cmd_a !== 8'h0) begin errors++; $display("FAIL mid_reset_out got %h/%h exp 0000/00", addr_a, cmd_a); end
    checks++; if ({dv_a, rv_a, err_a, busy_a} !== 4'b0) begin errors++; $display("FAIL mid_reset_strobes got %b exp 0000", {dv_a, rv_a, err_a, busy_a}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_addr = '0; m_cmd = '0; m_have = 0;
    hold(0, 1'b0, 40);
    checks++; if (er_cnt[0] - e0 !== 0) begin errors++; $display("FAIL mid_reset_silent got %0d exp 0", er_cnt[0] - e0); end
    b = make_frame(std_addr(8'($urandom)), 8'($urandom));
    d0 = dv_cnt[0];
    send_frame(0, b, 4);
    if (frame_ok(b, 0)) begin m_addr = b[15:0]; m_cmd = b[23:16]; m_have = 1; end
    checks++; if (dv_cnt[0] - d0 !== 1) begin errors++; $display("FAIL post_reset_dv got %0d exp 1", dv_cnt[0] - d0); end
    checks++; if (addr_a !== m_addr || cmd_a !== m_cmd) begin errors++; $display("FAIL post_reset_out got %h/%h exp %h/%h", addr_a, cmd_a, m_addr, m_cmd); end
  endtask

  initial begin
    test_reset();
    test_repeat_no_frame();
    fork
      test_frame();
      test_ext();
    join
    test_repeat();
    fork
      test_bad_inverse();
      test_ext_random();
    join
    test_timeout();
    test_reset_mid();
    checks++; if (excl_bad !== 0) begin errors++; $display("FAIL strobe_exclusive got %0d exp 0", excl_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
